// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial pattern detector with overlap mode and saturating match counter
module seq_detect_prog #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             in_vld,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);
  logic [PAT_W-1:0] pat_q, pat_d, hist_q, hist_d, nh, mask;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovl_q, ovl_d, err_q, err_d, match_q, match_d, hit, bad, rst_hist;
  always_comb begin
    nh = {hist_q[PAT_W-2:0], in};
    mask = {PAT_W{1'b1}} >> (LEN_W'(PAT_W) - len_q);
    bad = pat_len == '0 || pat_len > LEN_W'(PAT_W);
    hit = !cfg_load && in_vld && !err_q && len_q != '0
          && ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q}
          && ((nh ^ pat_q) & mask) == '0;
    rst_hist = cfg_load || (hit && !ovl_q);
    pat_d = cfg_load ? pat : pat_q;
    len_d = cfg_load ? pat_len : len_q;
    ovl_d = cfg_load ? overlap : ovl_q;
    err_d = cfg_load ? bad : err_q;
    match_d = hit;
    hist_d = rst_hist ? '0 : in_vld ? nh : hist_q;
    fill_d = rst_hist ? '0 : (in_vld && fill_q != LEN_W'(PAT_W)) ? fill_q + LEN_W'(1) : fill_q;
    cnt_d = cnt_clr ? '0 : (hit && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
      err_q <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      match_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      err_q <= err_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      match_q <= match_d;
      cnt_q <= cnt_d;
    end
  end
  assign match = match_q;
  assign match_cnt = cnt_q;
  assign cfg_err = err_q;
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: randomized and directed checks of seq_detect_prog against a queue-based model
module tb_seq_detect_prog;
  localparam int PW = 8;
  logic clk = 0, rst_n = 0, in = 0, in_vld = 0, cfg_load = 0, overlap = 0, cnt_clr = 0;
  logic [7:0] pat = 0;
  logic [3:0] pat_len = 0;
  logic match, match2, cfg_err, cfg_err2;
  logic [15:0] cnt;
  logic [1:0] cnt2;
  int tests = 0, fails = 0;
  bit m_err, m_ovl, em;
  int m_len, ec, ec2;
  logic [7:0] m_pat;
  bit q[$];
  always #5 clk = ~clk;
  seq_detect_prog #(.PAT_W(8), .LEN_W(4), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .in(in), .in_vld(in_vld), .cfg_load(cfg_load), .pat(pat),
    .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr), .match(match),
    .match_cnt(cnt), .cfg_err(cfg_err));
  seq_detect_prog #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in(in), .in_vld(in_vld), .cfg_load(cfg_load), .pat(pat),
    .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr), .match(match2),
    .match_cnt(cnt2), .cfg_err(cfg_err2));
  task automatic m_reset();
    m_err = 0; m_ovl = 0; m_len = 0; m_pat = 0; q.delete(); em = 0; ec = 0; ec2 = 0;
  endtask
  task automatic step(input bit b, input bit v, input bit l, input bit c);
    bit hit;
    @(negedge clk);
    in = b; in_vld = v; cfg_load = l; cnt_clr = c;
    @(posedge clk);
    hit = 0;
    if (l) begin
      m_pat = pat; m_len = pat_len; m_ovl = overlap;
      m_err = (pat_len == 0) || (pat_len > PW);
      q.delete();
    end else if (v) begin
      q.push_back(b);
      if (q.size() > PW) void'(q.pop_front());
      hit = !m_err && m_len > 0 && q.size() >= m_len;
      if (hit) for (int i = 0; i < m_len; i++) if (q[q.size()-1-i] != m_pat[i]) hit = 0;
      if (hit && !m_ovl) q.delete();
    end
    em = hit;
    if (c) begin ec = 0; ec2 = 0; end
    else if (hit) begin
      if (ec < 65535) ec++;
      if (ec2 < 3) ec2++;
    end
    #1;
  endtask
  task automatic load(input logic [7:0] p, input logic [3:0] len, input bit ovl);
    pat = p; pat_len = len; overlap = ovl;
    step(1'($urandom), 1, 1, 0);
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    tests++;
    if (match !== 0 || cnt !== 0 || cfg_err !== 0 || cnt2 !== 0 || u1.len_q !== 0) begin
      fails++;
      $display("FAIL reset: match=%0b cnt=%0d err=%0b len_q=%0d required all 0", match, cnt, cfg_err, u1.len_q);
    end
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0);
      tests++;
      if (match !== 0 || cnt !== 0) begin
        fails++;
        $display("FAIL unloaded: match=%0b cnt=%0d required 0 0", match, cnt);
      end
    end
  endtask
  task automatic test_10111(input bit ovl, input int want);
    logic [8:0] s = 9'b101110111;
    load(8'b10111, 5, ovl);
    step(0, 0, 0, 1);
    for (int i = 8; i >= 0; i--) begin
      step(s[i], 1, 0, 0);
      tests++;
      if (match !== em || cnt !== 16'(ec)) begin
        fails++;
        $display("FAIL p10111 ovl=%0b bit%0d: match=%0b cnt=%0d required %0b %0d", ovl, 9-i, match, cnt, em, ec);
      end
    end
    tests++;
    if (cnt !== 16'(want)) begin
      fails++;
      $display("FAIL p10111 total ovl=%0b: cnt=%0d required %0d", ovl, cnt, want);
    end
  endtask
  task automatic test_overlap();
    logic [7:0] s = 8'b10101101;
    for (int o = 1; o >= 0; o--) begin
      load(8'b101, 3, 1'(o));
      step(0, 0, 0, 1);
      for (int i = 7; i >= (o ? 3 : 0); i--) begin
        step(s[i], 1, 0, 0);
        tests++;
        if (match !== em || cnt !== 16'(ec)) begin
          fails++;
          $display("FAIL overlap%0d bit%0d: match=%0b cnt=%0d required %0b %0d", o, 8-i, match, cnt, em, ec);
        end
        if (i == 3) begin
          tests++;
          if (cnt !== (o ? 16'd2 : 16'd1)) begin
            fails++;
            $display("FAIL overlap%0d after 10101: cnt=%0d required %0d", o, cnt, o ? 2 : 1);
          end
        end
      end
    end
    tests++;
    if (cnt !== 16'd2) begin
      fails++;
      $display("FAIL nonoverlap continue: cnt=%0d required 2", cnt);
    end
  endtask
  task automatic test_gaps();
    logic [4:0] s = 5'b10101;
    int highs = 0;
    load(8'b101, 3, 1);
    step(0, 0, 0, 1);
    for (int i = 4; i >= 0; i--) begin
      step(s[i], 1, 0, 0);
      highs += int'(match);
      for (int g = 0; g < 3; g++) begin
        step(1'($urandom), 0, 0, 0);
        highs += int'(match);
        tests++;
        if (match !== 0) begin
          fails++;
          $display("FAIL gap bit%0d idle%0d: match=%0b required 0", 5-i, g, match);
        end
      end
    end
    tests++;
    if (cnt !== 16'd2 || highs != 2) begin
      fails++;
      $display("FAIL gaps total: cnt=%0d high_cycles=%0d required 2 2", cnt, highs);
    end
  endtask
  task automatic test_cfg_err();
    load(8'h5a, 0, 1);
    tests++;
    if (cfg_err !== 1 || cfg_err2 !== 1) begin
      fails++;
      $display("FAIL err len0: cfg_err=%0b required 1", cfg_err);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'($urandom), 1, 0, 0);
      tests++;
      if (match !== 0) begin
        fails++;
        $display("FAIL err len0 stream: match=%0b required 0", match);
      end
    end
    load(8'hff, 9, 1);
    tests++;
    if (cfg_err !== 1) begin
      fails++;
      $display("FAIL err len9: cfg_err=%0b required 1", cfg_err);
    end
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 0);
      tests++;
      if (match !== 0) begin
        fails++;
        $display("FAIL err len9 stream: match=%0b required 0", match);
      end
    end
    load(8'b11, 2, 1);
    tests++;
    if (cfg_err !== 0) begin
      fails++;
      $display("FAIL err cleared: cfg_err=%0b required 0", cfg_err);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      tests++;
      if (match !== (i > 0) || match !== em) begin
        fails++;
        $display("FAIL err resume bit%0d: match=%0b required %0b", i+1, match, i > 0);
      end
    end
  endtask
  task automatic test_saturate();
    load(8'b1, 1, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0);
      tests++;
      if (match !== 1 || match2 !== 1 || cnt2 !== 2'(ec2) || cnt !== 16'(ec)) begin
        fails++;
        $display("FAIL sat bit%0d: match=%0b cnt2=%0d cnt=%0d required 1 %0d %0d", i+1, match, cnt2, cnt, ec2, ec);
      end
    end
    tests++;
    if (cnt2 !== 2'd3 || cnt !== 16'd5) begin
      fails++;
      $display("FAIL sat final: cnt2=%0d cnt=%0d required 3 5", cnt2, cnt);
    end
    step(1, 1, 0, 1);
    tests++;
    if (match !== 1 || cnt !== 0 || cnt2 !== 0) begin
      fails++;
      $display("FAIL clr on match: match=%0b cnt=%0d cnt2=%0d required 1 0 0", match, cnt, cnt2);
    end
  endtask
  task automatic test_reset_mid();
    logic [4:0] s = 5'b10111;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        load(8'b10111, 5, 0);
        for (int i = 4; i >= 1; i--) step(s[i], 1, 0, 0);
      end else begin
        load(8'b1, 1, 1);
        step(1, 1, 0, 0);
        tests++;
        if (match !== 1) begin
          fails++;
          $display("FAIL pre-reset pulse: match=%0b required 1", match);
        end
      end
      #2 rst_n = 0;
      #1;
      m_reset();
      tests++;
      if (match !== 0 || cnt !== 0 || cfg_err !== 0 || cnt2 !== 0 || u1.len_q !== 0) begin
        fails++;
        $display("FAIL async reset%0d: match=%0b cnt=%0d err=%0b len_q=%0d required all 0", k, match, cnt, cfg_err, u1.len_q);
      end
      @(negedge clk) rst_n = 1;
    end
    for (int i = 4; i >= 0; i--) begin
      step(s[i], 1, 0, 0);
      tests++;
      if (match !== 0 || em !== 0) begin
        fails++;
        $display("FAIL post-reset no load: match=%0b required 0", match);
      end
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      if (n % 97 == 0) begin
        pat = 8'($urandom);
        pat_len = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 1) * 9) : 4'($urandom_range(1, 4));
        overlap = 1'($urandom);
        step(1'($urandom), 1'($urandom), 1, 0);
      end else begin
        step(1'($urandom), $urandom_range(0, 3) != 0, 0, $urandom_range(0, 49) == 0);
      end
      tests++;
      if (match !== em || cnt !== 16'(ec) || cnt2 !== 2'(ec2) || cfg_err !== m_err) begin
        fails++;
        $display("FAIL random cyc%0d: match=%0b cnt=%0d cnt2=%0d err=%0b required %0b %0d %0d %0b",
                 n, match, cnt, cnt2, cfg_err, em, ec, ec2, m_err);
      end
    end
  endtask
  initial begin
    test_reset();
    test_10111(1, 2);
    test_10111(0, 1);
    test_overlap();
    test_gaps();
    test_cfg_err();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
